// File: rtl/hist_mem_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hist_mem_sched: shares one single-port histogram BRAM between event increments,
// host readout and a full clear sweep.                               Rev 1.0
// ----------------------------------------------------------------------------
module hist_mem_sched #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 16,
    parameter int NUM_BINS = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              event_valid,
    input  logic [ADDR_W-1:0] event_bin,
    output logic              event_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              running,
    output logic              clear_done,
    output logic              sat_flag
);

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        INC_WR = 2'd1,
        RD_CAP = 2'd2,
        CLR    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NUM_BINS - 1);
    localparam logic [DATA_W-1:0] ALL_ONES = '1;

    state_t            state_q, state_d;
    logic              running_q, running_d;
    logic              clr_pend_q, clr_pend_d;
    logic              clear_done_q, clear_done_d;
    logic              sat_q, sat_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] bin_q, bin_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] rdata_inc;

    assign rdata_inc = mem_rdata + DATA_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB;
            running_q    <= 1'b0;
            clr_pend_q   <= 1'b1;
            clear_done_q <= 1'b0;
            sat_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
            clr_cnt_q    <= '0;
            bin_q        <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            running_q    <= running_d;
            clr_pend_q   <= clr_pend_d;
            clear_done_q <= clear_done_d;
            sat_q        <= sat_d;
            rd_valid_q   <= rd_valid_d;
            clr_cnt_q    <= clr_cnt_d;
            bin_q        <= bin_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Control pulses are folded into registers every cycle so none is lost.
    always_comb begin
        running_d = stop ? 1'b0 : (start ? 1'b1 : running_q);
    end

    always_comb begin
        state_d      = state_q;
        clr_pend_d   = clr_pend_q | clear;
        clear_done_d = clear_done_q;
        sat_d        = sat_q;
        rd_valid_d   = 1'b0;
        clr_cnt_d    = clr_cnt_q;
        bin_d        = bin_q;
        rd_data_d    = rd_data_q;
        event_ready  = 1'b0;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wdata    = '0;

        case (state_q)
            ARB: begin
                // While rd_valid is up the requester still holds rd_req for the
                // read just answered, so it must not be granted a second time.
                if (clr_pend_q) begin
                    clr_pend_d   = clear;
                    clr_cnt_d    = '0;
                    clear_done_d = 1'b0;
                    sat_d        = 1'b0;
                    state_d      = CLR;
                end else if (rd_req && !rd_valid_q) begin
                    mem_addr = rd_addr;
                    state_d  = RD_CAP;
                end else if (running_q && event_valid) begin
                    event_ready = 1'b1;
                    mem_addr    = event_bin;
                    bin_d       = event_bin;
                    state_d     = INC_WR;
                end
            end
            INC_WR: begin
                mem_we   = 1'b1;
                mem_addr = bin_q;
                if (mem_rdata == ALL_ONES) begin
                    mem_wdata = ALL_ONES;
                    sat_d     = 1'b1;
                end else begin
                    mem_wdata = rdata_inc;
                    if (rdata_inc == ALL_ONES) begin
                        sat_d = 1'b1;
                    end
                end
                state_d = ARB;
            end
            RD_CAP: begin
                rd_data_d  = mem_rdata;
                rd_valid_d = 1'b1;
                state_d    = ARB;
            end
            CLR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LAST_BIN) begin
                    clr_cnt_d    = '0;
                    clear_done_d = 1'b1;
                    state_d      = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign running    = running_q;
    assign clear_done = clear_done_q;
    assign sat_flag   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_hist_mem_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hist_mem_sched: BRAM model, vector table, corner sequences and a randomized
// run against a transaction-level histogram model.                   Rev 1.0
// ----------------------------------------------------------------------------
module tb_hist_mem_sched;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int NB = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, stop, clear, event_valid, rd_req;
    logic [AW-1:0] event_bin, rd_addr, mem_addr;
    logic          event_ready, rd_valid, mem_we, running, clear_done, sat_flag;
    logic [DW-1:0] rd_data, mem_wdata, mem_rdata;

    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;
    logic [DW-1:0] bram [NB];

    int checks = 0;
    int errors = 0;
    int ref_mem [NB];
    bit ref_sat;

    typedef struct {
        bit            run;
        bit            rd;
        logic [AW-1:0] ra;
        bit            ev;
        logic [AW-1:0] eb;
        bit            x_ready;
        bit            x_rd;
        logic [AW-1:0] x_addr;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    hist_mem_sched #(.ADDR_W(AW), .DATA_W(DW), .NUM_BINS(NB)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .event_valid(event_valid), .event_bin(event_bin), .event_ready(event_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .running(running), .clear_done(clear_done), .sat_flag(sat_flag)
    );

    // Single-port BRAM, read-first, one cycle read latency; bd_* is a bench backdoor.
    always @(posedge clk) begin
        if (bd_we) bram[bd_addr] <= bd_data;
        else if (mem_we) bram[mem_addr] <= mem_wdata;
        mem_rdata <= bram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NB; i++) ref_mem[i] = 0;
        ref_sat = 1'b0;
    endtask

    task automatic check_sweep(input string name);
        int n;
        int bad;
        n = 0;
        bad = 0;
        while (!(mem_we === 1'b1 && mem_addr == '0) && n < 1100) begin
            cyc(); #1;
            n++;
        end
        chk({name, "_found"}, 32'(n < 1100), 1);
        for (int i = 0; i < NB; i++) begin
            if (mem_we !== 1'b1 || mem_addr != AW'(i) || mem_wdata != '0 || clear_done !== 1'b0)
                bad++;
            cyc(); #1;
        end
        chk({name, "_bad_cycles"}, bad, 0);
        chk({name, "_clear_done"}, 32'(clear_done), 1);
        chk({name, "_we_after"}, 32'(mem_we), 0);
        model_clear();
    endtask

    task automatic check_bram(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < NB; i++)
            if (bram[i] != DW'(ref_mem[i])) bad++;
        chk(name, bad, 0);
    endtask

    task automatic do_read(input string name, input logic [AW-1:0] a, input int exp);
        rd_req = 1'b1;
        rd_addr = a;
        #1;
        chk({name, "_grant_addr"}, 32'(mem_addr), 32'(a));
        chk({name, "_grant_we"}, 32'(mem_we), 0);
        cyc(); #1;
        chk({name, "_valid_early"}, 32'(rd_valid), 0);
        cyc(); #1;
        chk({name, "_valid"}, 32'(rd_valid), 1);
        chk({name, "_data"}, 32'(rd_data), exp);
        cyc();
        rd_req = 1'b0;
        #1;
        chk({name, "_valid_pulse"}, 32'(rd_valid), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        bit run_m, ev_pend, rd_pend;
        int ev_wait, rd_wait, last_acc;

        start = 0; stop = 0; clear = 0; event_valid = 0; rd_req = 0;
        event_bin = '0; rd_addr = '0;
        bd_we = 0; bd_addr = '0; bd_data = '0;
        model_clear();
        reset = 1'b1;

        // Fill memory with junk under reset so the automatic sweep is visible.
        for (int i = 0; i < NB; i++) begin
            cyc();
            bd_we = 1'b1;
            bd_addr = AW'(i);
            bd_data = DW'($urandom_range(1, 65535));
        end
        cyc();
        bd_we = 1'b0;
        event_valid = 1'b1;
        #1;
        chk("rst_running", 32'(running), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_event_ready", 32'(event_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_clear_done", 32'(clear_done), 0);
        chk("rst_sat_flag", 32'(sat_flag), 0);
        event_valid = 1'b0;
        reset = 1'b0;
        check_sweep("reset_sweep");
        check_bram("reset_sweep_bram");

        // start, then three events on bin 5 with valid held
        start = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        chk("start_running", 32'(running), 1);
        event_valid = 1'b1;
        event_bin = 9'd5;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) event_valid = 1'b0;
            #1;
            chk($sformatf("burst_ready_%0d", k), 32'(event_ready), 32'(k % 2 == 0 && k < 5));
            cyc();
        end
        ref_mem[5] = 3;
        #1;
        chk("burst_bram5", 32'(bram[5]), 3);
        do_read("read5", 9'd5, 3);

        // read and event together: read first, event two cycles later
        rd_req = 1'b1; rd_addr = 9'd5;
        event_valid = 1'b1; event_bin = 9'd6;
        #1;
        chk("prio_ready0", 32'(event_ready), 0);
        chk("prio_addr0", 32'(mem_addr), 5);
        cyc(); #1;
        chk("prio_ready1", 32'(event_ready), 0);
        cyc(); #1;
        chk("prio_rd_valid", 32'(rd_valid), 1);
        chk("prio_rd_data", 32'(rd_data), 3);
        chk("prio_ready2", 32'(event_ready), 1);
        chk("prio_ev_addr", 32'(mem_addr), 6);
        cyc();
        rd_req = 1'b0;
        event_valid = 1'b0;
        #1;
        chk("prio_inc_we", 32'(mem_we), 1);
        chk("prio_inc_wdata", 32'(mem_wdata), 1);
        ref_mem[6] = 1;
        cyc();

        // saturation on bin 7
        bd_we = 1'b1; bd_addr = 9'd7; bd_data = 16'hFFFE;
        cyc();
        bd_we = 1'b0;
        #1;
        chk("sat_before", 32'(sat_flag), 0);
        event_valid = 1'b1;
        event_bin = 9'd7;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) event_valid = 1'b0;
            #1;
            if (k % 2 == 0) chk($sformatf("sat_ready_%0d", k), 32'(event_ready), 1);
            else chk($sformatf("sat_wdata_%0d", k), 32'(mem_wdata), 32'hFFFF);
            if (k == 2) chk("sat_after_first", 32'(sat_flag), 1);
            cyc();
        end
        #1;
        chk("sat_bram7", 32'(bram[7]), 32'hFFFF);
        chk("sat_flag", 32'(sat_flag), 1);

        // start and stop together, then stop during a write
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        event_valid = 1'b1; event_bin = 9'd8;
        #1;
        chk("startstop_running", 32'(running), 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stopped_ready_%0d", k), 32'(event_ready), 0);
            cyc(); #1;
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        chk("restart_ready", 32'(event_ready), 1);
        cyc();
        stop = 1'b1;
        #1;
        chk("stop_inc_we", 32'(mem_we), 1);
        cyc();
        stop = 1'b0;
        #1;
        chk("stop_running", 32'(running), 0);
        chk("stop_no_accept", 32'(event_ready), 0);
        cyc();
        event_valid = 1'b0;
        #1;
        chk("stop_bram8", 32'(bram[8]), 1);
        start = 1'b1;
        cyc();
        start = 1'b0;

        // clear during an event burst
        event_valid = 1'b1; event_bin = 9'd9;
        #1;
        chk("clrb_ready", 32'(event_ready), 1);
        cyc();
        clear = 1'b1;
        #1;
        chk("clrb_inc_we", 32'(mem_we), 1);
        chk("clrb_inc_addr", 32'(mem_addr), 9);
        cyc();
        clear = 1'b0;
        #1;
        chk("clrb_take_ready", 32'(event_ready), 0);
        chk("clrb_bram9", 32'(bram[9]), 1);
        event_valid = 1'b0;
        check_sweep("clr_burst");
        chk("clrb_running", 32'(running), 1);
        chk("clrb_sat_cleared", 32'(sat_flag), 0);

        // clear arriving mid-sweep restarts from bin 0 afterwards
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        for (int k = 0; k < 100; k++) cyc();
        #1;
        chk("mid_sweep_we", 32'(mem_we), 1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        #1;
        check_sweep("restart_sweep");
        cyc(); #1;
        chk("restart_done_held", 32'(clear_done), 1);
        cyc();

        // ARB decision table
        tbl = '{
            '{1'b1, 1'b0, 9'd0,   1'b0, 9'd0,   1'b0, 1'b0, 9'd0},
            '{1'b1, 1'b0, 9'd0,   1'b1, 9'd5,   1'b1, 1'b0, 9'd5},
            '{1'b1, 1'b1, 9'd9,   1'b0, 9'd0,   1'b0, 1'b1, 9'd9},
            '{1'b1, 1'b1, 9'd3,   1'b1, 9'd12,  1'b0, 1'b1, 9'd3},
            '{1'b0, 1'b0, 9'd0,   1'b1, 9'd4,   1'b0, 1'b0, 9'd0},
            '{1'b1, 1'b0, 9'd0,   1'b1, 9'd511, 1'b1, 1'b0, 9'd511},
            '{1'b0, 1'b1, 9'd20,  1'b1, 9'd21,  1'b0, 1'b1, 9'd20},
            '{1'b1, 1'b1, 9'd5,   1'b0, 9'd0,   1'b0, 1'b1, 9'd5},
            '{1'b1, 1'b1, 9'd511, 1'b1, 9'd5,   1'b0, 1'b1, 9'd511}
        };
        foreach (tbl[i]) begin
            if (running !== tbl[i].run) begin
                start = tbl[i].run;
                stop = !tbl[i].run;
                cyc();
                start = 1'b0;
                stop = 1'b0;
            end
            rd_req = tbl[i].rd; rd_addr = tbl[i].ra;
            event_valid = tbl[i].ev; event_bin = tbl[i].eb;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(event_ready), 32'(tbl[i].x_ready));
            chk($sformatf("tbl%0d_we", i), 32'(mem_we), 0);
            chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].x_addr));
            if (tbl[i].x_ready) ref_mem[tbl[i].eb] = sat_inc(ref_mem[tbl[i].eb]);
            cyc();
            event_valid = 1'b0;
            if (tbl[i].x_rd) begin
                cyc(); #1;
                chk($sformatf("tbl%0d_rd_valid", i), 32'(rd_valid), 1);
                chk($sformatf("tbl%0d_rd_data", i), 32'(rd_data), ref_mem[tbl[i].ra]);
                cyc();
            end
            rd_req = 1'b0;
            cyc();
            cyc();
        end

        // randomized traffic against the histogram model
        run_m = 1'b1;
        ev_pend = 1'b0; rd_pend = 1'b0;
        ev_wait = 0; rd_wait = 0; last_acc = -10;
        for (int c = 0; c < 800; c++) begin
            start = ($urandom_range(0, 39) == 0);
            stop = ($urandom_range(0, 59) == 0);
            if (!ev_pend && $urandom_range(0, 2) != 0) begin
                ev_pend = 1'b1;
                ev_wait = 0;
                event_bin = AW'($urandom_range(0, 15));
            end
            event_valid = ev_pend;
            if (!rd_pend && $urandom_range(0, 7) == 0) begin
                rd_pend = 1'b1;
                rd_wait = 0;
                rd_addr = AW'($urandom_range(0, 15));
            end
            rd_req = rd_pend;
            #1;
            chk("rnd_running", 32'(running), 32'(run_m));
            if (rd_valid === 1'b1) begin
                chk("rnd_rd_expected", 32'(rd_pend), 1);
                chk("rnd_rd_data", 32'(rd_data), ref_mem[rd_addr]);
                rd_pend = 1'b0;
            end else if (rd_pend) begin
                rd_wait++;
                if (rd_wait > 6) begin
                    chk("rnd_rd_timeout", 32'(rd_wait), 6);
                    rd_pend = 1'b0;
                end
            end
            if (event_valid && event_ready === 1'b1) begin
                chk("rnd_accept_while_running", 32'(run_m), 1);
                chk("rnd_accept_gap", 32'(c - last_acc >= 2), 1);
                last_acc = c;
                ref_mem[event_bin] = sat_inc(ref_mem[event_bin]);
                ev_pend = 1'b0;
            end else if (ev_pend && run_m) begin
                ev_wait++;
                if (ev_wait > 6) begin
                    chk("rnd_ev_timeout", 32'(ev_wait), 6);
                    ev_pend = 1'b0;
                end
            end
            run_m = stop ? 1'b0 : (start ? 1'b1 : run_m);
            cyc();
        end
        start = 1'b0; stop = 1'b0; event_valid = 1'b0; rd_req = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        #1;
        check_bram("rnd_bram");
        chk("rnd_sat_flag", 32'(sat_flag), 32'(ref_sat));

        // reset during a read-modify-write, then during a sweep
        start = 1'b1;
        cyc();
        start = 1'b0;
        event_valid = 1'b1; event_bin = 9'd3;
        v = int'(bram[3]);
        #1;
        chk("rmw_ready", 32'(event_ready), 1);
        cyc();
        reset = 1'b1;
        event_valid = 1'b0;
        #1;
        chk("rmw_reset_we", 32'(mem_we), 0);
        chk("rmw_reset_running", 32'(running), 0);
        cyc();
        #1;
        chk("rmw_abandoned", 32'(bram[3]), v);
        reset = 1'b0;
        for (int k = 0; k < 50; k++) cyc();
        reset = 1'b1;
        #1;
        chk("sweep_reset_we", 32'(mem_we), 0);
        chk("sweep_reset_clear_done", 32'(clear_done), 0);
        cyc();
        reset = 1'b0;
        #1;
        check_sweep("rst_mid_sweep");
        check_bram("rst_mid_sweep_bram");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
